// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding, parity types, majority helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversampling counter with three-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic                  bit_val
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]            samp_q, samp_d;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;

    // Edge counter and sample capture; the three samples straddle the bit centre
    always_comb begin
        half       = prescale >> 1;
        last       = prescale - PRESCALE_W'(1);
        edge_cnt_d = '0;
        samp_d     = samp_q;
        if (run) begin
            if (edge_cnt_q == last) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
            if (edge_cnt_q == half - PRESCALE_W'(1)) begin
                samp_d[0] = rx_in;
            end
            if (edge_cnt_q == half) begin
                samp_d[1] = rx_in;
            end
            if (edge_cnt_q == half + PRESCALE_W'(1)) begin
                samp_d[2] = rx_in;
            end
        end
        bit_done = run && (edge_cnt_q == last);
        bit_val  = majority3(samp_q[0], samp_q[1], samp_q[2]);
    end

    // Sampler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            samp_q     <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: frame FSM, data shift register, parity/stop checks, output pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;

    logic                  run;
    logic                  bit_done;
    logic                  bit_val;
    logic [PRESCALE_W-1:0] ps_use;

    // The start-edge cycle already counts as edge 0, so the sampler runs on it with the live Prescale
    always_comb begin
        run    = (state_q != IDLE) || !RX_IN;
        ps_use = (state_q == IDLE) ? Prescale : prescale_q;
    end

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .run      (run),
        .rx_in    (RX_IN),
        .prescale (ps_use),
        .bit_done (bit_done),
        .bit_val  (bit_val)
    );

    // Frame sequencing, data assembly and checks; output pulses land the cycle after the stop decision
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        p_data_d       = p_data_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_err_d      = par_err_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_err_d  = 1'b0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_err_d = bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d        = IDLE;
                    stop_error_d   = !bit_val;
                    parity_error_d = par_err_q;
                    data_valid_d   = bit_val && !par_err_q;
                    if (bit_val && !par_err_q) begin
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receiver state and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            p_data_q       <= '0;
            prescale_q     <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            p_data_q       <= p_data_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_err_q      <= par_err_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_valid   = data_valid_q;
    assign Parity_error = parity_error_q;
    assign Stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, corner sequences, randomized frames
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK          (clk),
        .RST          (rst),
        .RX_IN        (rx_in),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .P_DATA       (p_data),
        .Data_valid   (data_valid),
        .Parity_error (parity_error),
        .Stop_error   (stop_error)
    );

    typedef struct {
        int            cyc;
        bit            dv;
        bit            pe;
        bit            se;
        logic [DW-1:0] pd;
    } event_t;

    typedef struct {
        int            ps;
        bit            pen;
        bit            ptyp;
        logic [DW-1:0] data;
        bit            parbit;
        bit            stopb;
        int            flip_mode;
        bit            exp_dv;
        bit            exp_pe;
        bit            exp_se;
        logic [DW-1:0] exp_pd;
    } vec_t;

    event_t        obs_q[$];
    event_t        exp_q[$];
    bit            wave[$];
    bit            busy_m[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_pdata;

    task automatic check(input string what, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", what, idx, got, exp);
        end
    endtask

    // flip_mode: 0 none, 1 invert the sample at ps/2 of every bit, 2 invert one random centre sample per bit
    task automatic add_frame(input int ps, input logic [DW-1:0] data, input bit pen, input bit parbit,
                             input bit stopb, input int flip_mode);
        bit bits[$];
        int off;
        bits.push_back(1'b0);
        for (int b = 0; b < DW; b++) bits.push_back(data[b]);
        if (pen) bits.push_back(parbit);
        bits.push_back(stopb);
        foreach (bits[b]) begin
            off = -1;
            if (flip_mode == 1) off = ps / 2;
            if (flip_mode == 2 && $urandom_range(0, 3) != 0) off = ps / 2 - 1 + int'($urandom_range(0, 2));
            for (int c = 0; c < ps; c++) wave.push_back((c == off) ? ~bits[b] : bits[b]);
        end
    endtask

    function automatic bit line_at(input int i);
        if (i < wave.size()) return wave[i];
        return 1'b1;
    endfunction

    function automatic bit bit_at(input int s, input int b, input int ps);
        int m;
        int v;
        m = s + b * ps + ps / 2;
        v = int'(line_at(m - 1)) + int'(line_at(m)) + int'(line_at(m + 1));
        return v >= 2;
    endfunction

    // Line-level reference: find each falling start, vote each bit window, emit the expected result event
    task automatic run_model(input int ps, input bit pen, input bit ptyp);
        int            k;
        int            s;
        int            end_c;
        logic [DW-1:0] d;
        bit            pe;
        bit            sb;
        event_t        ev;
        exp_q.delete();
        busy_m.delete();
        for (int i = 0; i < wave.size() + 8; i++) busy_m.push_back(1'b0);
        k = 0;
        while (k < wave.size()) begin
            if (wave[k]) begin
                k++;
            end else begin
                s = k;
                if (bit_at(s, 0, ps)) begin
                    end_c = s + ps;
                end else begin
                    for (int b = 0; b < DW; b++) d[b] = bit_at(s, 1 + b, ps);
                    pe    = pen && (bit_at(s, 1 + DW, ps) != ((^d) ^ ptyp));
                    sb    = bit_at(s, 1 + DW + int'(pen), ps);
                    end_c = s + (2 + DW + int'(pen)) * ps;
                    ev.cyc = end_c;
                    ev.dv  = sb && !pe;
                    ev.pe  = pe;
                    ev.se  = !sb;
                    if (ev.dv) model_pdata = d;
                    ev.pd  = model_pdata;
                    exp_q.push_back(ev);
                end
                for (int i = s + 1; i < end_c && i < busy_m.size(); i++) busy_m[i] = 1'b1;
                k = end_c;
            end
        end
    endtask

    task automatic observe(input int k);
        event_t ev;
        if (data_valid || parity_error || stop_error) begin
            ev.cyc = k;
            ev.dv  = data_valid;
            ev.pe  = parity_error;
            ev.se  = stop_error;
            ev.pd  = p_data;
            obs_q.push_back(ev);
        end
    endtask

    // Plays the wave one cycle per entry; when scrambling, config inputs wander while a frame is in flight
    task automatic drive_wave(input int ps, input bit pen, input bit ptyp, input bit scramble);
        obs_q.delete();
        for (int k = 0; k < wave.size() + 6; k++) begin
            @(posedge clk);
            #1;
            rx_in = (k < wave.size()) ? wave[k] : 1'b1;
            if (scramble && k < busy_m.size() && busy_m[k]) begin
                prescale = PW'(8 << $urandom_range(0, 2));
                par_en   = 1'($urandom_range(0, 1));
                par_typ  = 1'($urandom_range(0, 1));
            end else begin
                prescale = PW'(ps);
                par_en   = pen;
                par_typ  = ptyp;
            end
            @(negedge clk);
            observe(k);
        end
    endtask

    task automatic cmp_events(input string what);
        check({what, ".count"}, 0, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({what, ".cycle"}, i, obs_q[i].cyc, exp_q[i].cyc);
            check({what, ".dv_pe_se"}, i, {obs_q[i].dv, obs_q[i].pe, obs_q[i].se},
                  {exp_q[i].dv, exp_q[i].pe, exp_q[i].se});
            check({what, ".p_data"}, i, obs_q[i].pd, exp_q[i].pd);
        end
    endtask

    task automatic expect_one(input int cyc, input bit dv, input bit pe, input bit se, input logic [DW-1:0] pd);
        event_t ev;
        ev.cyc = cyc;
        ev.dv  = dv;
        ev.pe  = pe;
        ev.se  = se;
        ev.pd  = pd;
        exp_q.push_back(ev);
    endtask

    vec_t vt[7];

    initial begin
        int            ps;
        bit            pen;
        bit            ptyp;
        int            nf;
        int            gap;
        int            g;
        logic [DW-1:0] d;
        bit            pb;
        bit            sb;

        vt[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[1] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[2] = '{8,  1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h3C};
        vt[3] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vt[4] = '{32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[5] = '{8,  1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h00};
        vt[6] = '{16, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'hFF};

        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = PW'(8);
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.p_data", 0, p_data, 0);
        check("reset.data_valid", 0, data_valid, 0);
        check("reset.parity_error", 0, parity_error, 0);
        check("reset.stop_error", 0, stop_error, 0);

        for (int i = 0; i < 7; i++) begin
            wave.delete();
            exp_q.delete();
            add_frame(vt[i].ps, vt[i].data, vt[i].pen, vt[i].parbit, vt[i].stopb, vt[i].flip_mode);
            expect_one((10 + int'(vt[i].pen)) * vt[i].ps, vt[i].exp_dv, vt[i].exp_pe, vt[i].exp_se, vt[i].exp_pd);
            drive_wave(vt[i].ps, vt[i].pen, vt[i].ptyp, 1'b0);
            cmp_events($sformatf("vec%0d", i));
        end

        // Two-cycle low glitch, then a clean frame starting at cycle 12
        wave.delete();
        exp_q.delete();
        wave.push_back(1'b0);
        wave.push_back(1'b0);
        repeat (10) wave.push_back(1'b1);
        add_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
        expect_one(92, 1'b1, 1'b0, 1'b0, 8'h5A);
        drive_wave(8, 1'b0, 1'b0, 1'b0);
        cmp_events("glitch");

        // Back-to-back frames at Prescale 32 with a corrupted centre sample in every bit
        wave.delete();
        exp_q.delete();
        add_frame(32, 8'h01, 1'b0, 1'b0, 1'b1, 1);
        add_frame(32, 8'hFE, 1'b0, 1'b0, 1'b1, 1);
        expect_one(320, 1'b1, 1'b0, 1'b0, 8'h01);
        expect_one(640, 1'b1, 1'b0, 1'b0, 8'hFE);
        drive_wave(32, 1'b0, 1'b0, 1'b0);
        cmp_events("b2b");

        // Reset during data bit 4, idle line, then a fresh frame
        wave.delete();
        obs_q.delete();
        add_frame(8, 8'h96, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 44; k++) begin
            @(posedge clk);
            #1;
            rx_in    = wave[k];
            prescale = PW'(8);
            par_en   = 1'b0;
            @(negedge clk);
            observe(k);
        end
        @(posedge clk);
        #1;
        rst   = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.p_data", 0, p_data, 0);
        check("rst_mid.data_valid", 0, data_valid, 0);
        check("rst_mid.parity_error", 0, parity_error, 0);
        check("rst_mid.stop_error", 0, stop_error, 0);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            observe(k);
        end
        check("rst_mid.pulses", 0, obs_q.size(), 0);
        wave.delete();
        exp_q.delete();
        add_frame(8, 8'h55, 1'b0, 1'b0, 1'b1, 0);
        expect_one(80, 1'b1, 1'b0, 1'b0, 8'h55);
        drive_wave(8, 1'b0, 1'b0, 1'b0);
        cmp_events("after_rst");

        model_pdata = 8'h55;
        for (int it = 0; it < 12; it++) begin
            ps   = 8 << $urandom_range(0, 2);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            wave.delete();
            nf = int'($urandom_range(1, 3));
            for (int f = 0; f < nf; f++) begin
                gap = int'($urandom_range(0, 4));
                repeat (gap) wave.push_back(1'b1);
                if ($urandom_range(0, 7) == 0) begin
                    g = int'($urandom_range(1, 2));
                    repeat (g) wave.push_back(1'b0);
                    repeat (ps) wave.push_back(1'b1);
                end else begin
                    d  = DW'($urandom);
                    pb = (^d) ^ ptyp;
                    if ($urandom_range(0, 5) == 0) pb = ~pb;
                    sb = ($urandom_range(0, 5) != 0);
                    add_frame(ps, d, pen, pb, sb, 2);
                end
            end
            run_model(ps, pen, ptyp);
            drive_wave(ps, pen, ptyp, 1'b1);
            cmp_events($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter PRESCALE_W, default 6: width of the Prescale input.
REQ-003 CLK  input  1  sole clock; all logic updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 RX_IN  input  1  serial line; idle high; already synchronised to CLK.
REQ-006 Prescale  input  PRESCALE_W  oversampling ratio (CLK cycles per bit); legal values 8, 16, 32.
REQ-007 PAR_EN  input  1  1 = a parity bit follows the data bits.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-010 Data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
REQ-011 Parity_error  output  1  one-cycle pulse: parity mismatch in the current frame.
REQ-012 Stop_error  output  1  one-cycle pulse: stop bit sampled as 0.

Function
REQ-013 Frame format SHALL be: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit 1.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, RX_IN=0 SHALL move the FSM to START; that cycle SHALL count as edge_cnt=0.
REQ-016 edge_cnt SHALL count 0..Prescale-1 per bit and wrap to 0; the bit decision SHALL be made on the cycle with edge_cnt=Prescale-1.
REQ-017 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 Prescale, PAR_EN and PAR_TYP SHALL be captured on IDLE->START; changes mid-frame SHALL be ignored.
REQ-019 START: a majority of 1 (glitch) SHALL return the FSM to IDLE with no outputs asserted; a majority of 0 SHALL move it to DATA.
REQ-020 DATA: bit_cnt SHALL count 0..DATA_WIDTH-1 and shift each bit into a shift register; after the last bit go to PARITY if PAR_EN=1, else to STOP.
REQ-021 PARITY: Parity_error SHALL be set when the sampled bit differs from the XOR of the data bits (inverted when PAR_TYP=1); the FSM then goes to STOP.
REQ-022 STOP: on the decision cycle the FSM SHALL go to IDLE.
REQ-023 On the cycle after the stop decision, Data_valid SHALL pulse and P_DATA SHALL load the shift register only when stop=1 and no parity error occurred.
REQ-024 Parity_error and Stop_error SHALL pulse on that same cycle; both MAY assert together; Data_valid SHALL then stay 0.
REQ-025 P_DATA SHALL hold its value between Data_valid pulses.
REQ-026 Back-to-back frames SHALL be supported: RX_IN=0 on the first IDLE cycle after STOP SHALL start a new frame.
REQ-027 An illegal Prescale value is undefined behaviour and need not be detected.

Reset
REQ-028 RST=1 SHALL, on the next CLK edge, force state IDLE, all counters 0, P_DATA 0, and Data_valid, Parity_error and Stop_error 0.
REQ-029 Reset mid-frame SHALL abort the frame without any output pulse; reception SHALL restart on the next falling start edge after RST=0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding and the PAR_EVEN/PAR_ODD constants, shared with the transmit side.
REQ-031 One sub-module, uart_rx_sampler, SHALL contain edge_cnt, the three-sample majority vote, and a bit_done strobe.
REQ-032 The FSM, bit counter, shift register, parity check and output registers SHALL reside in uart_rx.

Verification
REQ-033 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 -> P_DATA=0xA5 and one Data_valid pulse 1 cycle after the stop decision (cycle 88 from the start edge).
REQ-034 Same frame with PAR_TYP=1 and parity bit 0 -> Parity_error pulse, Data_valid=0, P_DATA unchanged.
REQ-035 Prescale=16, PAR_EN=0, frame 0x3C with stop bit 0 -> Stop_error pulse, no Data_valid.
REQ-036 Idle line with a 2-cycle low glitch (Prescale=8) -> FSM returns to IDLE, no output pulses.
REQ-037 Prescale=32, two back-to-back frames 0x01 then 0xFE, plus one flipped sample per bit at edge_cnt=Prescale/2 -> two Data_valid pulses with the correct data.
REQ-038 RST asserted during bit 4 of a frame -> outputs 0, no pulse; the next frame 0x55 is received correctly.
